// File: rtl/score_keeper.sv
`timescale 1ns/1ps
// Purpose: game-logic stage; edge-detected hit/miss/start/game_over events drive a saturating combo score, high score and game FSM.
// Latency: an event sampled at clock edge N is reflected on every output right after edge N; no further pipelining.
// Backpressure: none; event inputs are always accepted and outputs are always valid.
module score_keeper #(
    parameter int MAX_SCORE   = 999,
    parameter int BASE_POINTS = 1,
    parameter int MAX_MULT    = 4,
    parameter int COMBO_STEP  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic       game_over,
    output logic [9:0] score,
    output logic [9:0] high_score,
    output logic [2:0] multiplier,
    output logic       playing,
    output logic       new_high
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_OVER    = 2'd2
    } state_t;

    state_t      state;
    logic        start_d;
    logic        hit_d;
    logic        miss_d;
    logic        game_over_d;
    logic [3:0]  hit_cnt;

    logic        start_rise;
    logic        hit_rise;
    logic        miss_rise;
    logic        game_over_rise;
    logic [10:0] score_sum;
    logic [9:0]  score_sat;
    logic [3:0]  cnt_inc;
    logic        combo_done;

    assign start_rise     = start & ~start_d;
    assign hit_rise       = hit & ~hit_d;
    assign miss_rise      = miss & ~miss_d;
    assign game_over_rise = game_over & ~game_over_d;

    // Delay flops for rising-edge detection; cleared at reset so a level already high counts on the first clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_d     <= 1'b0;
            hit_d       <= 1'b0;
            miss_d      <= 1'b0;
            game_over_d <= 1'b0;
        end else begin
            start_d     <= start;
            hit_d       <= hit;
            miss_d      <= miss;
            game_over_d <= game_over;
        end
    end

    // Next score (11-bit sum so it cannot wrap, then clamp) and combo counter step.
    always_comb begin
        score_sum  = {1'b0, score} + 11'(BASE_POINTS) * {8'd0, multiplier};
        score_sat  = (score_sum > 11'(MAX_SCORE)) ? 10'(MAX_SCORE) : score_sum[9:0];
        cnt_inc    = hit_cnt + 4'd1;
        combo_done = (cnt_inc == 4'(COMBO_STEP));
    end

    // Game FSM with registered outputs; game_over beats miss beats hit within one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            score      <= 10'd0;
            high_score <= 10'd0;
            multiplier <= 3'd1;
            hit_cnt    <= 4'd0;
            playing    <= 1'b0;
            new_high   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_OVER: begin
                    if (start_rise) begin
                        state      <= S_PLAYING;
                        playing    <= 1'b1;
                        score      <= 10'd0;
                        multiplier <= 3'd1;
                        hit_cnt    <= 4'd0;
                        new_high   <= 1'b0;
                    end
                end
                S_PLAYING: begin
                    if (game_over_rise) begin
                        state   <= S_OVER;
                        playing <= 1'b0;
                        // Ties do not count as a new record.
                        if (score > high_score) begin
                            high_score <= score;
                            new_high   <= 1'b1;
                        end
                    end else if (miss_rise) begin
                        multiplier <= 3'd1;
                        hit_cnt    <= 4'd0;
                    end else if (hit_rise) begin
                        score <= score_sat;
                        if (combo_done) begin
                            hit_cnt <= 4'd0;
                            if (multiplier < 3'(MAX_MULT)) begin
                                multiplier <= multiplier + 3'd1;
                            end
                        end else begin
                            hit_cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    playing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for score_keeper using a vector table plus hand-built corner sequences.
// Latency: each applied vector is checked 1 ns after the clock edge that consumes it.
// Backpressure: none; the DUT has no flow control.
module tb_score_keeper;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       hit;
    logic       miss;
    logic       game_over;
    logic [9:0] score;
    logic [9:0] high_score;
    logic [2:0] multiplier;
    logic       playing;
    logic       new_high;

    typedef struct {
        logic s;
        logic h;
        logic m;
        logic g;
        int   sc;
        int   mu;
        int   pl;
        int   hs;
        int   nh;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vidx     = 0;

    score_keeper #(
        .MAX_SCORE  (999),
        .BASE_POINTS(1),
        .MAX_MULT   (4),
        .COMBO_STEP (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .hit       (hit),
        .miss      (miss),
        .game_over (game_over),
        .score     (score),
        .high_score(high_score),
        .multiplier(multiplier),
        .playing   (playing),
        .new_high  (new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s (vector %0d): got %0d expected %0d", name, vidx, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic h, input logic m, input logic g,
                       input int sc, input int mu, input int pl, input int hs, input int nh);
        vec_t v;
        v.s = s; v.h = h; v.m = m; v.g = g;
        v.sc = sc; v.mu = mu; v.pl = pl; v.hs = hs; v.nh = nh;
        tbl.push_back(v);
    endtask

    // One hit pulse followed by a low cycle; both cycles expect the same outputs.
    task automatic hitp(input int sc, input int mu, input int hs, input int nh);
        add(1'b0, 1'b1, 1'b0, 1'b0, sc, mu, 1, hs, nh);
        add(1'b0, 1'b0, 1'b0, 1'b0, sc, mu, 1, hs, nh);
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard (vector %0d): got empty queue expected an entry", vidx);
        end else begin
            e = exp_q.pop_front();
            chk("score", int'(score), e.sc);
            chk("multiplier", int'(multiplier), e.mu);
            chk("playing", int'(playing), e.pl);
            chk("high_score", int'(high_score), e.hs);
            chk("new_high", int'(new_high), e.nh);
        end
        vidx++;
    endtask

    task automatic step(input logic s, input logic h, input logic m, input logic g,
                        input int sc, input int mu, input int pl, input int hs, input int nh);
        vec_t v;
        v.s = s; v.h = h; v.m = m; v.g = g;
        v.sc = sc; v.mu = mu; v.pl = pl; v.hs = hs; v.nh = nh;
        start = s; hit = h; miss = m; game_over = g;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic drive_only(input logic s, input logic h, input logic m, input logic g);
        start = s; hit = h; miss = m; game_over = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Game 0: ignored events in IDLE, basic hits, start ignored while playing, ignores in OVER.
        add(0, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 0, 0);
        hitp(1, 1, 0, 0);
        hitp(2, 1, 0, 0);
        hitp(3, 1, 0, 0);
        add(1, 0, 0, 0, 3, 1, 1, 0, 0);
        add(0, 0, 0, 1, 3, 1, 0, 3, 1);
        add(0, 1, 0, 0, 3, 1, 0, 3, 1);
        add(0, 0, 1, 0, 3, 1, 0, 3, 1);
        add(0, 0, 0, 0, 3, 1, 0, 3, 1);
        // Game 1: held hit counts once, combo ramps, miss resets multiplier.
        add(1, 0, 0, 0, 0, 1, 1, 3, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 1, 1, 1, 3, 0);
        add(0, 0, 0, 0, 1, 1, 1, 3, 0);
        hitp(2, 1, 3, 0);
        hitp(3, 1, 3, 0);
        hitp(4, 2, 3, 0);
        hitp(6, 2, 3, 0);
        hitp(8, 2, 3, 0);
        hitp(10, 2, 3, 0);
        hitp(12, 3, 3, 0);
        add(0, 0, 1, 0, 12, 1, 1, 3, 0);
        add(0, 0, 0, 0, 12, 1, 1, 3, 0);
        add(0, 0, 0, 1, 12, 1, 0, 12, 1);
        add(0, 0, 0, 0, 12, 1, 0, 12, 1);
        // Game 2: ends equal to the record, so no new high.
        add(1, 0, 0, 0, 0, 1, 1, 12, 0);
        hitp(1, 1, 12, 0);
        hitp(2, 1, 12, 0);
        hitp(3, 1, 12, 0);
        hitp(4, 2, 12, 0);
        hitp(6, 2, 12, 0);
        hitp(8, 2, 12, 0);
        hitp(10, 2, 12, 0);
        hitp(12, 3, 12, 0);
        add(0, 0, 0, 1, 12, 3, 0, 12, 0);
        add(0, 0, 0, 0, 12, 3, 0, 12, 0);
        // Game 3: simultaneous hit+miss, then game_over+hit.
        add(1, 0, 0, 0, 0, 1, 1, 12, 0);
        hitp(1, 1, 12, 0);
        hitp(2, 1, 12, 0);
        hitp(3, 1, 12, 0);
        hitp(4, 2, 12, 0);
        add(0, 1, 1, 0, 4, 1, 1, 12, 0);
        add(0, 0, 0, 0, 4, 1, 1, 12, 0);
        hitp(5, 1, 12, 0);
        add(0, 1, 0, 1, 5, 1, 0, 12, 0);
        add(0, 0, 0, 0, 5, 1, 0, 12, 0);

        resetn = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0; game_over = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset score", int'(score), 0);
        chk("reset multiplier", int'(multiplier), 1);
        chk("reset playing", int'(playing), 0);
        chk("reset high_score", int'(high_score), 0);
        chk("reset new_high", int'(new_high), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].h, tbl[i].m, tbl[i].g,
                 tbl[i].sc, tbl[i].mu, tbl[i].pl, tbl[i].hs, tbl[i].nh);
        end

        // Saturation: 252 hits reach 984 at multiplier 4, then steer to 997 at multiplier 3.
        step(1, 0, 0, 0, 0, 1, 1, 12, 0);
        for (int i = 0; i < 252; i++) begin
            drive_only(0, 1, 0, 0);
            drive_only(0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 984, 4, 1, 12, 0);
        step(0, 0, 1, 0, 984, 1, 1, 12, 0);
        step(0, 0, 0, 0, 984, 1, 1, 12, 0);
        step(0, 1, 0, 0, 985, 1, 1, 12, 0);
        step(0, 0, 0, 0, 985, 1, 1, 12, 0);
        step(0, 0, 1, 0, 985, 1, 1, 12, 0);
        step(0, 0, 0, 0, 985, 1, 1, 12, 0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0, 985 + i, (i == 4) ? 2 : 1, 1, 12, 0);
            step(0, 0, 0, 0, 985 + i, (i == 4) ? 2 : 1, 1, 12, 0);
        end
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 0, 0, 989 + 2 * i, (i == 4) ? 3 : 2, 1, 12, 0);
            step(0, 0, 0, 0, 989 + 2 * i, (i == 4) ? 3 : 2, 1, 12, 0);
        end
        step(0, 1, 0, 0, 999, 3, 1, 12, 0);
        step(0, 0, 0, 0, 999, 3, 1, 12, 0);
        step(0, 1, 0, 0, 999, 3, 1, 12, 0);
        step(0, 0, 0, 0, 999, 3, 1, 12, 0);
        step(0, 0, 0, 1, 999, 3, 0, 999, 1);
        step(0, 0, 0, 0, 999, 3, 0, 999, 1);

        // Asynchronous reset mid-game wipes everything, including the high score.
        step(1, 0, 0, 0, 0, 1, 1, 999, 0);
        step(0, 1, 0, 0, 1, 1, 1, 999, 0);
        #2;
        resetn = 1'b0;
        #1;
        chk("async score", int'(score), 0);
        chk("async multiplier", int'(multiplier), 1);
        chk("async playing", int'(playing), 0);
        chk("async high_score", int'(high_score), 0);
        chk("async new_high", int'(new_high), 0);

        // start already high at reset release produces an event on the first clock.
        start = 1'b1;
        hit   = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 1, 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
